// File: rtl/microwave_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : microwave_ctrl_pkg
// Purpose : shared state encodings and keypad digit limits
// Revision: 1.0
// ============================================================================
package microwave_ctrl_pkg;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_entry = 3'd1;
  localparam logic [2:0] c_st_load  = 3'd2;
  localparam logic [2:0] c_st_cook  = 3'd3;
  localparam logic [2:0] c_st_pause = 3'd4;
  localparam logic [2:0] c_st_done  = 3'd5;

  // 9 bounds the ones and minutes digits, 5 the seconds-tens digit
  localparam logic [3:0] c_digit_max  = 4'd9;
  localparam logic [3:0] c_tens_max   = 4'd5;
  localparam logic [1:0] c_digits_max = 2'd3;

endpackage
`default_nettype wire

// File: rtl/microwave_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : microwave_ctrl_if
// Purpose : keypad/button inputs and counter-chain controls of the sequencer
// Revision: 1.0
// ============================================================================
interface microwave_ctrl_if;

  logic       key_valid;
  logic [3:0] key_val;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       zero_in;
  logic       loadn;
  logic       en;
  logic [3:0] min_data;
  logic [3:0] tens_data;
  logic [3:0] ones_data;
  logic       mag_on;
  logic       done;
  logic [2:0] state;

  modport master (
    output key_valid, key_val, startn, stopn, door_closed, zero_in,
    input  loadn, en, min_data, tens_data, ones_data, mag_on, done, state
  );

  modport slave (
    input  key_valid, key_val, startn, stopn, door_closed, zero_in,
    output loadn, en, min_data, tens_data, ones_data, mag_on, done, state
  );

endinterface
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Purpose : divides cook time into countdown steps of TICK_DIV clocks
// Revision: 1.0
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int               CNT_W  = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = (count_q == c_last) ? '0 : count_q + 1'b1;
    end
  end

  // Look-ahead on the next count so the registered enable lines up with it
  assign tick = (count_d == c_last);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/microwave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : microwave_ctrl
// Purpose : keypad entry, load/cook/pause/done sequencing of the countdown chain
// Revision: 1.0
// ============================================================================
module microwave_ctrl
  import microwave_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic            clk,
  input  logic            clrn,
  microwave_ctrl_if.slave bus
);

  logic [2:0] state_q, state_d;
  logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [1:0] ndig_q, ndig_d;
  logic       startn_q, startn_d, stopn_q, stopn_d;
  logic       armed_q, armed_d;
  logic       loadn_q, loadn_d, en_q, en_d, mag_on_q, mag_on_d, done_q, done_d;
  logic       start_edge, stop_edge, key_digit, key_ok, entry_nz, tick;

  always_comb begin
    startn_d   = bus.startn;
    stopn_d    = bus.stopn;
    start_edge = startn_q & ~bus.startn;
    stop_edge  = stopn_q & ~bus.stopn;
    key_digit  = bus.key_valid && (bus.key_val <= c_digit_max);
    // a ones digit above 5 would shift into the tens position
    key_ok     = key_digit && (ndig_q != c_digits_max) && (ones_q <= c_tens_max);
    entry_nz   = |{min_q, tens_q, ones_q};
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .clrn  (clrn),
    .clear (state_q == c_st_load),
    .run   (state_q == c_st_cook),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry priority: stop, then start, then a key
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (key_ok) state_d = c_st_entry;
      c_st_entry: begin
        if (stop_edge)                                    state_d = c_st_idle;
        else if (start_edge && bus.door_closed && entry_nz) state_d = c_st_load;
      end
      c_st_load:  state_d = c_st_cook;
      c_st_cook: begin
        if (armed_q && bus.zero_in)             state_d = c_st_done;
        else if (!bus.door_closed || stop_edge) state_d = c_st_pause;
      end
      c_st_pause: begin
        if (stop_edge)                             state_d = c_st_idle;
        else if (start_edge && bus.door_closed)    state_d = c_st_cook;
      end
      c_st_done:  if (stop_edge || start_edge || key_digit) state_d = c_st_idle;
      default:    state_d = c_st_idle;
    endcase
  end

  always_comb begin
    loadn_d  = (state_d != c_st_load);
    en_d     = (state_d == c_st_cook) && tick;
    mag_on_d = (state_d == c_st_cook);
    done_d   = (state_d == c_st_done);
  end

  always_comb begin
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ndig_d  = ndig_q;
    armed_d = armed_q;
    if (state_d == c_st_idle) begin
      min_d  = '0;
      tens_d = '0;
      ones_d = '0;
      ndig_d = '0;
    end else if (key_ok && (state_d == c_st_entry)) begin
      min_d  = tens_q;
      tens_d = ones_q;
      ones_d = bus.key_val;
      ndig_d = ndig_q + 2'd1;
    end
    // zero_in is stale on the first cook cycle after a load
    if (state_q == c_st_load) begin
      armed_d = 1'b0;
    end else if (state_q == c_st_cook) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      min_q    <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      ndig_q   <= '0;
      armed_q  <= 1'b0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      loadn_q  <= 1'b1;
      en_q     <= 1'b0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      min_q    <= min_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      ndig_q   <= ndig_d;
      armed_q  <= armed_d;
      startn_q <= startn_d;
      stopn_q  <= stopn_d;
      loadn_q  <= loadn_d;
      en_q     <= en_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
    end
  end

  assign bus.loadn     = loadn_q;
  assign bus.en        = en_q;
  assign bus.mag_on    = mag_on_q;
  assign bus.done      = done_q;
  assign bus.state     = state_q;
  assign bus.min_data  = min_q;
  assign bus.tens_data = tens_q;
  assign bus.ones_data = ones_q;

endmodule
`default_nettype wire
